// File: rtl/sido_rail_monitor_if.sv
// ADC handshake bundle shared between the rail monitor (master) and the ADC front-end (slave).
interface sido_rail_monitor_if;
   logic        adc_start;
   logic        adc_sel;
   logic        adc_done;
   logic [11:0] adc_data;

   modport master (output adc_start, output adc_sel, input adc_done, input adc_data);
   modport slave  (input adc_start, input adc_sel, output adc_done, output adc_data);
endinterface

// File: rtl/sido_rail_monitor.sv
// SIDO rail monitor: sequences the shared ADC over both rails, derives hysteretic request and
// debounced emergency flags. Optional two-tap error filter via RAIL_MON_FILTER_EN.
module sido_rail_monitor #(
   parameter logic [11:0] REF_3V3     = 12'd2048,
   parameter logic [11:0] REF_5V      = 12'd2048,
   parameter int          REQ_ON      = 8,
   parameter int          REQ_OFF     = -4,
   parameter int          EMG_ON      = 200,
   parameter int          EMG_OFF     = 100,
   parameter int unsigned EMG_CNT     = 2,
   parameter int unsigned SAMPLE_GAP  = 4,
   parameter int unsigned ADC_TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   sido_rail_monitor_if.master       adc,
   output logic                      request_3V3,
   output logic                      request_5V,
   output logic                      emergency_3v3,
   output logic                      emergency_5v,
   output logic signed [12:0]        error_3v3,
   output logic signed [12:0]        error_5v,
   output logic                      update_strobe,
   output logic                      adc_fault
);

   typedef enum logic [2:0] {StIdle, StStart, StWait, StUpdate, StGap} state_e;

   localparam int unsigned       CntW     = (EMG_CNT < 2) ? 1 : $clog2(EMG_CNT + 1);
   localparam logic signed [12:0] ReqOn   = 13'(REQ_ON);
   localparam logic signed [12:0] ReqOff  = 13'(REQ_OFF);
   localparam logic signed [12:0] EmgOn   = 13'(EMG_ON);
   localparam logic signed [12:0] EmgOff  = 13'(EMG_OFF);
   localparam logic [CntW-1:0]    EmgCntC = CntW'(EMG_CNT);
   localparam logic [15:0]        WaitEnd = 16'(ADC_TIMEOUT - 1);

   state_e                 state_q, state_d;
   logic [15:0]            wait_cnt_q, wait_cnt_d, gap_cnt_q, gap_cnt_d;
   logic                   sel_q, sel_d, rail_q, rail_d, pend_q, pend_d;
   logic                   strobe_q, strobe_d, fault_q, fault_d;
   logic [11:0]            data_q, data_d;
   logic signed [12:0]     new_err_q, new_err_d;
   logic signed [12:0]     err_q [2];
   logic signed [12:0]     err_d [2];
   logic                   req_q [2];
   logic                   req_d [2];
   logic                   emg_q [2];
   logic                   emg_d [2];
   logic [CntW-1:0]        cnt_q [2];
   logic [CntW-1:0]        cnt_d [2];

   logic [11:0]            ref_sel;
   logic signed [12:0]     raw_err, upd_err;
   logic [CntW-1:0]        cnt_nx;
   logic                   emg_nx, req_nx;

   assign ref_sel = sel_q ? REF_5V : REF_3V3;
   assign raw_err = $signed({1'b0, ref_sel}) - $signed({1'b0, data_q});

`ifdef RAIL_MON_FILTER_EN
   logic signed [12:0]     prev_q [2];
   logic signed [12:0]     prev_d [2];
   logic signed [13:0]     filt_sum;
   assign filt_sum = 14'(raw_err) + 14'(prev_q[sel_q]);
   assign upd_err  = 13'(filt_sum >>> 1);
`else
   assign upd_err  = raw_err;
`endif

   // Threshold evaluation for the rail whose update is pending.
   always_comb begin
      cnt_nx = '0;
      if (new_err_q > EmgOn) begin
         cnt_nx = (cnt_q[rail_q] < EmgCntC) ? cnt_q[rail_q] + 1'b1 : cnt_q[rail_q];
      end
      emg_nx = emg_q[rail_q];
      if (new_err_q < EmgOff) begin
         emg_nx = 1'b0;
         cnt_nx = '0;
      end else if (cnt_nx >= EmgCntC) begin
         emg_nx = 1'b1;
      end
      req_nx = req_q[rail_q];
      if (new_err_q > ReqOn) begin
         req_nx = 1'b1;
      end else if (new_err_q < ReqOff) begin
         req_nx = 1'b0;
      end
      if (emg_nx) req_nx = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      sel_d      = sel_q;
      rail_d     = rail_q;
      pend_d     = 1'b0;
      strobe_d   = 1'b0;
      fault_d    = fault_q;
      data_d     = data_q;
      new_err_d  = new_err_q;
      err_d      = err_q;
      req_d      = req_q;
      emg_d      = emg_q;
      cnt_d      = cnt_q;
`ifdef RAIL_MON_FILTER_EN
      prev_d     = prev_q;
`endif
      unique case (state_q)
         StIdle:  state_d = StStart;
         StStart: begin
            wait_cnt_d = '0;
            state_d    = StWait;
         end
         StWait: begin
            if (adc.adc_done) begin
               data_d  = adc.adc_data;
               state_d = StUpdate;
            end else if (wait_cnt_q == WaitEnd) begin
               fault_d   = 1'b1;
               req_d     = '{default: 1'b0};
               emg_d     = '{default: 1'b0};
               cnt_d     = '{default: '0};
               gap_cnt_d = '0;
               state_d   = StGap;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         StUpdate: begin
            new_err_d = upd_err;
            rail_d    = sel_q;
            pend_d    = 1'b1;
            sel_d     = ~sel_q;
            gap_cnt_d = '0;
            state_d   = StGap;
`ifdef RAIL_MON_FILTER_EN
            prev_d[sel_q] = raw_err;
`endif
         end
         StGap: begin
            if (32'(gap_cnt_q) + 32'd1 >= SAMPLE_GAP) begin
               state_d = StStart;
            end else begin
               gap_cnt_d = gap_cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Registered error from UPDATE is committed one edge later, together with the strobe.
      if (pend_q) begin
         err_d[rail_q] = new_err_q;
         req_d[rail_q] = req_nx;
         emg_d[rail_q] = emg_nx;
         cnt_d[rail_q] = cnt_nx;
         fault_d       = 1'b0;
         strobe_d      = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         gap_cnt_q  <= '0;
         sel_q      <= 1'b0;
         rail_q     <= 1'b0;
         pend_q     <= 1'b0;
         strobe_q   <= 1'b0;
         fault_q    <= 1'b0;
         data_q     <= '0;
         new_err_q  <= '0;
         err_q      <= '{default: '0};
         req_q      <= '{default: 1'b0};
         emg_q      <= '{default: 1'b0};
         cnt_q      <= '{default: '0};
`ifdef RAIL_MON_FILTER_EN
         prev_q     <= '{default: '0};
`endif
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         sel_q      <= sel_d;
         rail_q     <= rail_d;
         pend_q     <= pend_d;
         strobe_q   <= strobe_d;
         fault_q    <= fault_d;
         data_q     <= data_d;
         new_err_q  <= new_err_d;
         err_q      <= err_d;
         req_q      <= req_d;
         emg_q      <= emg_d;
         cnt_q      <= cnt_d;
`ifdef RAIL_MON_FILTER_EN
         prev_q     <= prev_d;
`endif
      end
   end

   assign adc.adc_start   = (state_q == StStart);
   assign adc.adc_sel     = sel_q;
   assign request_3V3     = req_q[0];
   assign request_5V      = req_q[1];
   assign emergency_3v3   = emg_q[0];
   assign emergency_5v    = emg_q[1];
   assign error_3v3       = err_q[0];
   assign error_5v        = err_q[1];
   assign update_strobe   = strobe_q;
   assign adc_fault       = fault_q;

endmodule

// File: tb/tb_sido_rail_monitor.sv
// Scoreboard bench for sido_rail_monitor: directed ADC samples, expected outputs queued per
// conversion and checked by a monitor on each update_strobe.
module tb_sido_rail_monitor;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sido_rail_monitor_if adc ();

   logic              r3, r5, m3, m5, strobe, fault;
   logic signed [12:0] e3, e5;

   sido_rail_monitor dut (
      .clk           (clk),
      .reset         (reset),
      .adc           (adc),
      .request_3V3   (r3),
      .request_5V    (r5),
      .emergency_3v3 (m3),
      .emergency_5v  (m5),
      .error_3v3     (e3),
      .error_5v      (e5),
      .update_strobe (strobe),
      .adc_fault     (fault)
   );

   typedef struct {
      logic [11:0]        data;
      logic signed [12:0] err;
      logic               req;
      logic               emg;
   } vec_t;

   typedef struct {
      logic signed [12:0] e3;
      logic signed [12:0] e5;
      logic               r3;
      logic               r5;
      logic               m3;
      logic               m5;
      logic               fault;
      int                 cyc;
   } exp_t;

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   logic  exp_sel;
   exp_t  cur;
   exp_t  sb[$];
   vec_t  vecs[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int d, input int e, input bit r, input bit m);
      vec_t v;
      v.data = 12'(d);
      v.err  = 13'(e);
      v.req  = r;
      v.emg  = m;
      return v;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset === 1'b0 && strobe === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_strobe", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("error_3v3", e3, e.e3);
            chk("error_5v", e5, e.e5);
            chk("request_3V3", r3, e.r3);
            chk("request_5V", r5, e.r5);
            chk("emergency_3v3", m3, e.m3);
            chk("emergency_5v", m5, e.m5);
            chk("adc_fault_at_update", fault, e.fault);
            chk("strobe_latency", cyc, e.cyc);
         end
      end
   end

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (adc.adc_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("adc_start_timeout", 0, 1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_e3"}, e3, 0);
      chk({tag, "_e5"}, e5, 0);
      chk({tag, "_r3"}, r3, 0);
      chk({tag, "_r5"}, r5, 0);
      chk({tag, "_m3"}, m3, 0);
      chk({tag, "_m5"}, m5, 0);
      chk({tag, "_fault"}, fault, 0);
      chk({tag, "_strobe"}, strobe, 0);
   endtask

   task automatic convert(input vec_t v, input int dly, input bit started);
      bit ok;
      ok = 1'b1;
      if (!started) wait_start(ok);
      if (!ok) return;
      chk("adc_sel", adc.adc_sel, exp_sel);
      @(posedge clk);
      repeat (dly) @(posedge clk);
      #1;
      adc.adc_done = 1'b1;
      adc.adc_data = v.data;
      @(posedge clk);
      #1;
      adc.adc_done = 1'b0;
      if (exp_sel == 1'b0) begin
         cur.e3 = v.err;
         cur.r3 = v.req;
         cur.m3 = v.emg;
      end else begin
         cur.e5 = v.err;
         cur.r5 = v.req;
         cur.m5 = v.emg;
      end
      cur.fault = 1'b0;
      cur.cyc   = cyc + 2;
      sb.push_back(cur);
      exp_sel = ~exp_sel;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n;
      reset        = 1'b1;
      adc.adc_done = 1'b0;
      adc.adc_data = '0;
      exp_sel      = 1'b0;
      cur          = '{e3: 0, e5: 0, r3: 0, r5: 0, m3: 0, m5: 0, fault: 0, cyc: 0};

`ifdef RAIL_MON_FILTER_EN
      vecs.push_back(mk(2028, 10, 1, 0));
      vecs.push_back(mk(2048, 0, 0, 0));
      vecs.push_back(mk(2048, 10, 1, 0));
`else
      vecs.push_back(mk(2030, 18, 1, 0));
      vecs.push_back(mk(1800, 248, 1, 0));
      vecs.push_back(mk(2050, -2, 1, 0));
      vecs.push_back(mk(1800, 248, 1, 1));
      vecs.push_back(mk(2053, -5, 0, 0));
      vecs.push_back(mk(1960, 88, 1, 0));
      vecs.push_back(mk(4095, -2047, 0, 0));
      vecs.push_back(mk(0, 2048, 1, 0));
`endif

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_zero("reset");
      chk("reset_adc_start", adc.adc_start, 0);
      chk("reset_adc_sel", adc.adc_sel, 0);

      for (int i = 0; i < vecs.size(); i++) convert(vecs[i], i % 4, 1'b0);

`ifndef RAIL_MON_FILTER_EN
      // Timeout: leave adc_done low for the whole WAIT window.
      wait_start(ok);
      chk("timeout_sel", adc.adc_sel, exp_sel);
      repeat (64) @(posedge clk);
      @(negedge clk);
      chk("fault_before_timeout", fault, 0);
      @(posedge clk);
      @(negedge clk);
      chk("fault_on_timeout", fault, 1);
      chk("timeout_r3", r3, 0);
      chk("timeout_r5", r5, 0);
      chk("timeout_m3", m3, 0);
      chk("timeout_m5", m5, 0);
      chk("timeout_e3_hold", e3, -2047);
      chk("timeout_e5_hold", e5, 2048);
      n = 0;
      while (n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (adc.adc_start === 1'b1) break;
      end
      chk("gap_after_timeout", n, 4);
      cur.r3 = 1'b0;
      cur.r5 = 1'b0;
      cur.m3 = 1'b0;
      cur.m5 = 1'b0;
      convert(mk(2048, 0, 0, 0), 1, 1'b1);
      convert(mk(1800, 248, 1, 0), 2, 1'b0);
      convert(mk(2100, -52, 0, 0), 0, 1'b0);
`endif

      // Reset in the middle of a 5V WAIT, followed by a stray adc_done.
      wait_start(ok);
      chk("pre_reset_sel", adc.adc_sel, 1);
      @(posedge clk);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      reset        = 1'b0;
      adc.adc_done = 1'b1;
      adc.adc_data = 12'd0;
      @(negedge clk);
      check_zero("post_reset");
      chk("post_reset_idle_start", adc.adc_start, 0);
      @(negedge clk);
      chk("restart_adc_start", adc.adc_start, 1);
      chk("restart_sel", adc.adc_sel, 0);
      @(posedge clk);
      #1 adc.adc_done = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      check_zero("stray_done");
      chk("scoreboard_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
